seq_control_unit: RTL and testbench
===================================

Name: seq_control_unit

Overview:
- Fetch/decode/execute sequencer for the downsampling processor.
- Steps the program counter and drives the instruction-memory read.
- Handshakes with data memory.
- Issues ALU operations and runs the zero-flag register protocol for conditional jumps.
- Sits between instruction memory and the datapath. Only one datapath resource is enabled per state.

Parameters:
- PC_W, 12: program counter and address width.
- INSTR_W, 16: instruction width; opcode in [INSTR_W-1:INSTR_W-4], operand in [PC_W-1:0].

Ports:
- clk  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin execution at PC 0 (sampled in IDLE)
- instr_in  in  INSTR_W  instruction memory data; valid the cycle after imem_rd
- imem_rd  out  1  instruction memory read strobe
- pc_out  out  PC_W  instruction address
- alu_op  out  3  ALU function: 0 ADD, 1 SUB, 2 INC, 3 PASS
- alu_start  out  1  ALU executes this cycle
- z_alu_en  out  1  zero register captures ALU zero this cycle
- z_out_en  out  1  zero register drives its value on next edge
- z_in  in  1  zero register output
- dm_req  out  1  data memory request; held until dm_ack
- dm_we  out  1  1 write, 0 read; stable while dm_req
- dm_addr  out  PC_W  data memory address; stable while dm_req
- dm_ack  in  1  data memory completion, single-cycle pulse
- busy  out  1  high in every state except IDLE and HALT
- done  out  1  one-cycle pulse on entry to HALT

Behaviour:
- Reset (async, any state): state=IDLE; PC=0; IR=0; every output 0.
- IDLE: start=1 -> FETCH, PC=0.
- FETCH: imem_rd=1, pc_out=PC -> LATCH.
- LATCH: IR<=instr_in; PC<=PC+1, wrapping modulo 2^PC_W -> EXEC.
- Opcodes (IR[top 4 bits]):
  - 0 NOP: -> FETCH.
  - 1 LOAD: -> MEM with dm_we=0.
  - 2 STORE: -> MEM with dm_we=1.
  - 3 ADD, 4 SUB, 5 INC, 6 PASS: one EXEC cycle with alu_start=1, z_alu_en=1, alu_op mapped 0/1/2/3 -> FETCH.
  - 7 JMP: PC<=operand -> FETCH.
  - 8 JZ, 9 JNZ: -> ZREQ.
  - F HALT: -> HALT.
  - Undefined opcodes A-E: treated as NOP.
- MEM: dm_req=1, dm_addr=operand, dm_we held; stay until dm_ack=1, then -> FETCH with dm_req=0 on the next cycle. dm_ack outside MEM is ignored.
- ZREQ: z_out_en=1 for exactly one cycle -> ZEVAL.
- ZEVAL: sample z_in.
  - JZ with z_in=1, or JNZ with z_in=0: PC<=operand.
  - Otherwise PC unchanged.
  - -> FETCH.
  - Branch latency: 2 cycles after EXEC.
- Exclusivity: z_alu_en and z_out_en are never asserted in the same cycle. The zero register gives ALU_EN priority, so overlap would lose the read.
- Cycle counts: NOP/ALU/JMP take 3 cycles per instruction; JZ/JNZ take 5; LOAD/STORE take 3 + wait cycles, minimum 4 if dm_ack arrives in the first MEM cycle.
- HALT: done=1 on the entry cycle only, busy=0. Stays in HALT; start=1 -> FETCH with PC=0.
- start while busy: ignored.
- Reset mid-MEM: dm_req drops immediately (asynchronously); no retry after reset.
- Outputs are registered state decodes; no combinational path from an input to an output except the async reset.

Test Plan:
- Reset then start; program NOP, NOP, HALT -> imem_rd at PC 0,1,2; done pulses 9 cycles after start; busy=0 afterwards.
- ADD at PC 0 -> EXEC cycle shows alu_start=1, z_alu_en=1, alu_op=0, z_out_en=0; next fetch at PC 1.
- JZ 0x040 with z_in=1 in ZEVAL -> next pc_out=0x040. JNZ 0x040 with z_in=1 -> next pc_out=PC+1. Check z_out_en high exactly one cycle and never overlapping z_alu_en.
- LOAD 0x123 with dm_ack delayed 5 cycles -> dm_req high 6 cycles, dm_addr=0x123, dm_we=0; STORE repeat -> dm_we=1 throughout.
- JMP 0xFFF, then NOP at 0xFFF -> following fetch at PC 0x000 (wrap).
- Assert RST during MEM wait -> all outputs 0 at once, state IDLE. Then start -> fetch from PC 0.

Source files
------------

// File: rtl/seq_control_unit.sv
// ---------------------------------------------------------------------------
// seq_control_unit
//   Fetch/decode/execute sequencer for the downsampling processor. Steps the
//   program counter, drives the instruction-memory read, handshakes with data
//   memory, issues ALU operations and runs the zero-flag register protocol for
//   conditional jumps. Only one datapath resource is enabled per state.
//
// Ports
//   clk       in   clock, all state on rising edge
//   RST       in   asynchronous active-high reset
//   start     in   begin execution at PC 0 (sampled in IDLE / HALT)
//   instr_in  in   instruction memory data, valid the cycle after imem_rd
//   imem_rd   out  instruction memory read strobe
//   pc_out    out  instruction address
//   alu_op    out  ALU function: 0 ADD, 1 SUB, 2 INC, 3 PASS
//   alu_start out  ALU executes this cycle
//   z_alu_en  out  zero register captures ALU zero this cycle
//   z_out_en  out  zero register drives its value on next edge
//   z_in      in   zero register output
//   dm_req    out  data memory request, held until dm_ack
//   dm_we     out  1 write, 0 read; stable while dm_req
//   dm_addr   out  data memory address; stable while dm_req
//   dm_ack    in   data memory completion pulse
//   busy      out  high in every state except IDLE and HALT
//   done      out  one-cycle pulse on entry to HALT
// ---------------------------------------------------------------------------
module seq_control_unit #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               imem_rd,
    output logic [PC_W-1:0]    pc_out,
    output logic [2:0]         alu_op,
    output logic               alu_start,
    output logic               z_alu_en,
    output logic               z_out_en,
    input  logic               z_in,
    output logic               dm_req,
    output logic               dm_we,
    output logic [PC_W-1:0]    dm_addr,
    input  logic               dm_ack,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_MEM, S_ZREQ, S_ZEVAL, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_INC   = 4'h5;
    localparam logic [3:0] OP_PASS  = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t               r_state;
    state_t               w_next;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_done;

    logic [3:0]           w_opcode;
    logic [PC_W-1:0]      w_operand;
    logic                 w_is_alu;
    logic                 w_take;

    assign w_opcode  = r_ir[INSTR_W-1 -: 4];
    assign w_operand = r_ir[PC_W-1:0];
    assign w_is_alu  = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                       (w_opcode == OP_INC) || (w_opcode == OP_PASS);
    // JZ branches on zero set, JNZ on zero clear.
    assign w_take    = (w_opcode == OP_JZ) ? z_in : ~z_in;

    // State, PC, IR and the done pulse register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            // done is high only for the first cycle spent in HALT.
            r_done  <= (w_next == S_HALT) && (r_state != S_HALT);
            case (r_state)
                S_IDLE, S_HALT: if (start) r_pc <= '0;
                S_LATCH: begin
                    r_ir <= instr_in;
                    r_pc <= r_pc + PC_W'(1);
                end
                S_EXEC:  if (w_opcode == OP_JMP) r_pc <= w_operand;
                S_ZEVAL: if (w_take) r_pc <= w_operand;
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_LATCH;
            S_LATCH: w_next = S_EXEC;
            S_EXEC: begin
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_JZ, OP_JNZ:     w_next = S_ZREQ;
                    OP_HALT:           w_next = S_HALT;
                    // NOP, ALU ops, JMP and undefined opcodes return to fetch.
                    default:           w_next = S_FETCH;
                endcase
            end
            S_MEM:   if (dm_ack) w_next = S_FETCH;
            S_ZREQ:  w_next = S_ZEVAL;
            S_ZEVAL: w_next = S_FETCH;
            S_HALT:  if (start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset clears them at once.
    always_comb begin
        imem_rd   = 1'b0;
        pc_out    = r_pc;
        alu_op    = 3'd0;
        alu_start = 1'b0;
        z_alu_en  = 1'b0;
        z_out_en  = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        busy      = (r_state != S_IDLE) && (r_state != S_HALT);
        done      = r_done;
        case (r_state)
            S_FETCH: imem_rd = 1'b1;
            S_EXEC: begin
                if (w_is_alu) begin
                    alu_start = 1'b1;
                    z_alu_en  = 1'b1;
                    alu_op    = 3'(w_opcode - OP_ADD);
                end
            end
            S_MEM: begin
                dm_req  = 1'b1;
                dm_we   = (w_opcode == OP_STORE);
                dm_addr = w_operand;
            end
            // z_out_en lives in its own state, so it never meets z_alu_en.
            S_ZREQ:  z_out_en = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_control_unit
//   Directed testbench for seq_control_unit. A small instruction memory model
//   returns imem[pc_out] the cycle after imem_rd; data-memory acks and the
//   zero flag are driven directly. Cycle index kN below means the Nth negedge
//   after the edge that sampled start (k0 is the first FETCH cycle).
// ---------------------------------------------------------------------------
module tb_seq_control_unit;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               RST;
    logic               start;
    logic [INSTR_W-1:0] instr_in;
    logic               imem_rd;
    logic [PC_W-1:0]    pc_out;
    logic [2:0]         alu_op;
    logic               alu_start;
    logic               z_alu_en;
    logic               z_out_en;
    logic               z_in;
    logic               dm_req;
    logic               dm_we;
    logic [PC_W-1:0]    dm_addr;
    logic               dm_ack;
    logic               busy;
    logic               done;

    logic [INSTR_W-1:0] imem [0:(1<<PC_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    seq_control_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .RST       (RST),
        .start     (start),
        .instr_in  (instr_in),
        .imem_rd   (imem_rd),
        .pc_out    (pc_out),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .z_alu_en  (z_alu_en),
        .z_out_en  (z_out_en),
        .z_in      (z_in),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_ack    (dm_ack),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) instr_in <= imem[pc_out];
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < (1 << PC_W); i++) imem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        RST = 1'b1; start = 1'b0; dm_ack = 1'b0; z_in = 1'b0;
        tick(); tick();
        RST = 1'b0;
        tick();
    endtask

    // Pulse start for one edge; returns at k0.
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int zc;
    int ov;

    initial begin
        RST = 1'b1; start = 1'b0; dm_ack = 1'b0; z_in = 1'b0;

        // ---- Reset state and NOP, NOP, HALT ----
        fill_halt();
        imem[0] = 16'h0000;
        imem[1] = 16'h0000;
        do_reset();
        chk_eq("rst_imem_rd", imem_rd, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_done", done, 1'b0);
        chk_eq("rst_pc", pc_out, 12'h000);
        chk_eq("rst_dm_req", dm_req, 1'b0);
        chk_eq("rst_alu_start", alu_start, 1'b0);
        chk_eq("rst_z_out_en", z_out_en, 1'b0);
        kick();                                            // k0
        chk_eq("t1_rd0", imem_rd, 1'b1);
        chk_eq("t1_pc0", pc_out, 12'h000);
        tick(); tick(); tick();                            // k3
        chk_eq("t1_rd1", imem_rd, 1'b1);
        chk_eq("t1_pc1", pc_out, 12'h001);
        chk_eq("t1_busy", busy, 1'b1);
        start = 1'b1; tick(); start = 1'b0;                // k4, start ignored
        tick(); tick();                                    // k6
        chk_eq("t1_rd2", imem_rd, 1'b1);
        chk_eq("t1_pc2", pc_out, 12'h002);
        tick(); tick();                                    // k8
        chk_eq("t1_done_early", done, 1'b0);
        tick();                                            // k9
        chk_eq("t1_done", done, 1'b1);
        chk_eq("t1_busy_halt", busy, 1'b0);
        tick();                                            // k10
        chk_eq("t1_done_pulse", done, 1'b0);
        chk_eq("t1_busy_after", busy, 1'b0);
        chk_eq("t1_rd_halt", imem_rd, 1'b0);
        kick();                                            // restart from HALT
        chk_eq("t1_restart_rd", imem_rd, 1'b1);
        chk_eq("t1_restart_pc", pc_out, 12'h000);

        // ---- ADD then INC ----
        fill_halt();
        imem[0] = 16'h3000;
        imem[1] = 16'h5000;
        do_reset();
        kick(); tick(); tick();                            // k2 EXEC ADD
        chk_eq("t2_add_start", alu_start, 1'b1);
        chk_eq("t2_add_zen", z_alu_en, 1'b1);
        chk_eq("t2_add_op", alu_op, 3'd0);
        chk_eq("t2_add_zout", z_out_en, 1'b0);
        tick();                                            // k3
        chk_eq("t2_fetch_pc", pc_out, 12'h001);
        chk_eq("t2_fetch_rd", imem_rd, 1'b1);
        chk_eq("t2_start_off", alu_start, 1'b0);
        chk_eq("t2_zen_off", z_alu_en, 1'b0);
        tick(); tick();                                    // k5 EXEC INC
        chk_eq("t2_inc_start", alu_start, 1'b1);
        chk_eq("t2_inc_op", alu_op, 3'd2);

        // ---- JZ 0x040 taken with z_in=1 ----
        fill_halt();
        imem[0] = 16'h8040;
        do_reset();
        z_in = 1'b1;
        zc = 0; ov = 0;
        kick();
        for (int k = 0; k < 6; k++) begin
            if (z_out_en) zc++;
            if (z_out_en && z_alu_en) ov++;
            if (k == 3) chk_eq("t3_zreq", z_out_en, 1'b1);
            if (k < 5) tick();
        end                                                // k5
        chk_eq("t3_jz_pc", pc_out, 12'h040);
        chk_eq("t3_jz_rd", imem_rd, 1'b1);
        chk_eq("t3_zout_cycles", zc, 1);
        chk_eq("t3_overlap", ov, 0);

        // ---- JNZ 0x040 not taken with z_in=1 ----
        fill_halt();
        imem[0] = 16'h9040;
        do_reset();
        z_in = 1'b1;
        kick();
        for (int k = 0; k < 5; k++) tick();                // k5
        chk_eq("t3_jnz_pc", pc_out, 12'h001);
        chk_eq("t3_jnz_rd", imem_rd, 1'b1);

        // ---- LOAD 0x123 with ack in sixth MEM cycle, then STORE ----
        fill_halt();
        imem[0] = 16'h1123;
        imem[1] = 16'h2123;
        do_reset();
        kick(); tick(); tick(); tick();                    // k3 first MEM cycle
        for (int i = 0; i < 6; i++) begin
            chk_eq($sformatf("t4_ld_req%0d", i), dm_req, 1'b1);
            chk_eq($sformatf("t4_ld_addr%0d", i), dm_addr, 12'h123);
            chk_eq($sformatf("t4_ld_we%0d", i), dm_we, 1'b0);
            if (i == 5) dm_ack = 1'b1;
            tick();
        end                                                // k9
        dm_ack = 1'b0;
        chk_eq("t4_ld_req_drop", dm_req, 1'b0);
        chk_eq("t4_ld_next_pc", pc_out, 12'h001);
        chk_eq("t4_ld_next_rd", imem_rd, 1'b1);
        tick(); tick(); tick();                            // k12 MEM STORE
        chk_eq("t4_st_req", dm_req, 1'b1);
        chk_eq("t4_st_we", dm_we, 1'b1);
        chk_eq("t4_st_addr", dm_addr, 12'h123);
        dm_ack = 1'b1;
        tick();                                            // k13
        dm_ack = 1'b0;
        chk_eq("t4_st_req_drop", dm_req, 1'b0);
        chk_eq("t4_st_we_drop", dm_we, 1'b0);
        chk_eq("t4_st_next_pc", pc_out, 12'h002);

        // ---- JMP 0xFFF, NOP at 0xFFF wraps to 0x000 ----
        fill_halt();
        imem[0]     = 16'h7FFF;
        imem[12'hFFF] = 16'h0000;
        do_reset();
        kick(); tick(); tick(); tick();                    // k3
        chk_eq("t5_jmp_pc", pc_out, 12'hFFF);
        chk_eq("t5_jmp_rd", imem_rd, 1'b1);
        tick(); tick(); tick();                            // k6
        chk_eq("t5_wrap_pc", pc_out, 12'h000);
        chk_eq("t5_wrap_rd", imem_rd, 1'b1);

        // ---- Reset during MEM wait ----
        fill_halt();
        imem[0] = 16'h1055;
        do_reset();
        kick(); tick(); tick(); tick();                    // k3 MEM
        chk_eq("t6_req_before", dm_req, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk_eq("t6_async_req", dm_req, 1'b0);
        chk_eq("t6_async_addr", dm_addr, 12'h000);
        chk_eq("t6_async_busy", busy, 1'b0);
        chk_eq("t6_async_pc", pc_out, 12'h000);
        tick(); tick();
        RST = 1'b0;
        dm_ack = 1'b1; tick(); dm_ack = 1'b0;
        tick();
        chk_eq("t6_no_retry", dm_req, 1'b0);
        chk_eq("t6_idle_busy", busy, 1'b0);
        kick();
        chk_eq("t6_restart_rd", imem_rd, 1'b1);
        chk_eq("t6_restart_pc", pc_out, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
